// File: rtl/primitive_assembly.sv
// Primitive assembly: groups every three vertex beats into a triangle, culls
// triangles that reuse a vertex id, and queues the rest in a small FIFO.
module primitive_assembly #(
  parameter int DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  // Handshake: the vertex side has no ready; every beat with valid_in=1 is
  // taken on the rising edge. On the triangle side a transfer happens on a
  // rising edge where valid_out=1 and ready_in=1; while valid_out=1 and
  // ready_in=0 the head triangle is held stable on the outputs.
  input  logic                  valid_in,
  input  logic [15:0]           vertex_id_in,
  input  logic [2:0][31:0]      position_in,
  input  logic [2:0][31:0]      normal_in,
  input  logic [11:0]           material_in,
  input  logic                  flush_in,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [2:0][2:0][31:0] position_out,
  output logic [2:0][2:0][31:0] normal_out,
  output logic [11:0]           material_out,
  output logic [15:0]           tri_id_out,
  output logic [15:0]           cull_count_out,
  output logic                  overflow_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  // Partial triangle: slot counter plus the first two vertices.
  logic [1:0]       slot;
  logic [15:0]      id0, id1;
  logic [2:0][31:0] pos0, pos1, nrm0, nrm1;
  logic [11:0]      mat0;

  // FIFO state; the extra top pointer bit separates full from empty.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [15:0]      push_cnt;
  logic [15:0]      cull_cnt;
  logic             ovf;

  logic [2:0][2:0][31:0] pos_mem [DEPTH];
  logic [2:0][2:0][31:0] nrm_mem [DEPTH];
  logic [11:0]           mat_mem [DEPTH];
  logic [15:0]           tid_mem [DEPTH];

  logic complete, degen, push_req, empty, full, pop, push;

  // A beat in slot 2 closes the triangle using the live input as vertex 2.
  always_comb begin
    complete = valid_in && !flush_in && (slot == 2'd2);
    degen    = (id0 == id1) || (id0 == vertex_id_in) || (id1 == vertex_id_in);
    push_req = complete && !degen;
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop      = !empty && ready_in;
    // A pop on the same edge frees the head slot, so a full FIFO still accepts.
    push     = push_req && (!full || pop);
  end

  // Slot counter and storage of vertices 0 and 1; flush restarts the triangle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot <= 2'd0;
      id0  <= '0;
      id1  <= '0;
      pos0 <= '0;
      pos1 <= '0;
      nrm0 <= '0;
      nrm1 <= '0;
      mat0 <= '0;
    end else if (flush_in) begin
      if (valid_in) begin
        id0  <= vertex_id_in;
        pos0 <= position_in;
        nrm0 <= normal_in;
        mat0 <= material_in;
        slot <= 2'd1;
      end else begin
        slot <= 2'd0;
      end
    end else if (valid_in) begin
      case (slot)
        2'd0: begin
          id0  <= vertex_id_in;
          pos0 <= position_in;
          nrm0 <= normal_in;
          mat0 <= material_in;
          slot <= 2'd1;
        end
        2'd1: begin
          id1  <= vertex_id_in;
          pos1 <= position_in;
          nrm1 <= normal_in;
          slot <= 2'd2;
        end
        default: slot <= 2'd0;
      endcase
    end
  end

  // FIFO pointers, triangle sequence number, cull counter and sticky overflow.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      push_cnt <= '0;
      cull_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        push_cnt <= push_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (complete && degen) cull_cnt <= cull_cnt + 16'd1;
      if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  // Triangle storage; vertex order is arrival order, index 0 first.
  always_ff @(posedge clk_in) begin
    if (push) begin
      pos_mem[wr_ptr[AW-1:0]] <= {position_in, pos1, pos0};
      nrm_mem[wr_ptr[AW-1:0]] <= {normal_in, nrm1, nrm0};
      mat_mem[wr_ptr[AW-1:0]] <= mat0;
      tid_mem[wr_ptr[AW-1:0]] <= push_cnt;
    end
  end

  assign valid_out      = !empty;
  assign position_out   = pos_mem[rd_ptr[AW-1:0]];
  assign normal_out     = nrm_mem[rd_ptr[AW-1:0]];
  assign material_out   = mat_mem[rd_ptr[AW-1:0]];
  assign tri_id_out     = tid_mem[rd_ptr[AW-1:0]];
  assign cull_count_out = cull_cnt;
  assign overflow_out   = ovf;

endmodule

// File: tb/tb_primitive_assembly.sv
// Bench for primitive_assembly: directed vertex streams, a triangle
// scoreboard queue, and per-cycle checks of the status outputs.
module tb_primitive_assembly;

  localparam int DEPTH = 4;
  localparam int W     = 604;

  logic                  clk_in = 1'b0;
  logic                  rst_in = 1'b0;
  logic                  valid_in = 1'b0;
  logic [15:0]           vertex_id_in = '0;
  logic [2:0][31:0]      position_in = '0;
  logic [2:0][31:0]      normal_in = '0;
  logic [11:0]           material_in = '0;
  logic                  flush_in = 1'b0;
  logic                  ready_in = 1'b0;
  logic                  valid_out;
  logic [2:0][2:0][31:0] position_out;
  logic [2:0][2:0][31:0] normal_out;
  logic [11:0]           material_out;
  logic [15:0]           tri_id_out;
  logic [15:0]           cull_count_out;
  logic                  overflow_out;

  primitive_assembly #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
    .vertex_id_in(vertex_id_in), .position_in(position_in),
    .normal_in(normal_in), .material_in(material_in), .flush_in(flush_in),
    .ready_in(ready_in), .valid_out(valid_out), .position_out(position_out),
    .normal_out(normal_out), .material_out(material_out),
    .tri_id_out(tri_id_out), .cull_count_out(cull_count_out),
    .overflow_out(overflow_out)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  // Scoreboard and reference state
  logic [W-1:0]     exp_q[$];
  logic [15:0]      exp_cull = '0;
  logic             exp_ovf = 1'b0;
  int               m_slot = 0;
  logic [15:0]      m_tri = '0;
  logic [15:0]      m_id0, m_id1;
  logic [2:0][31:0] m_pos0, m_pos1, m_nrm0, m_nrm1;
  logic [11:0]      m_mat0;
  int               n_checks = 0;
  int               n_pass = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cull = '0;
    exp_ovf  = 1'b0;
    m_slot   = 0;
    m_tri    = '0;
  endtask

  // Reference behaviour for one accepted beat, evaluated at the sampling edge.
  task automatic model_beat(input logic [15:0] id, input logic [2:0][31:0] p,
                            input logic [2:0][31:0] n, input logic [11:0] m,
                            input logic fl);
    if (fl || m_slot == 0) begin
      m_id0 = id; m_pos0 = p; m_nrm0 = n; m_mat0 = m; m_slot = 1;
    end else if (m_slot == 1) begin
      m_id1 = id; m_pos1 = p; m_nrm1 = n; m_slot = 2;
    end else begin
      m_slot = 0;
      if (m_id0 == m_id1 || m_id0 == id || m_id1 == id) exp_cull++;
      else if (exp_q.size() < DEPTH) begin
        exp_q.push_back({m_tri, m_mat0, {p, m_pos1, m_pos0}, {n, m_nrm1, m_nrm0}});
        m_tri++;
      end else exp_ovf = 1'b1;
    end
  endtask

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] id, input logic fl);
    logic [2:0][31:0] p, n;
    logic [11:0] m;
    for (int k = 0; k < 3; k++) begin
      p[k] = $urandom;
      n[k] = $urandom;
    end
    m = 12'($urandom_range(0, 4095));
    valid_in = 1'b1; flush_in = fl; vertex_id_in = id;
    position_in = p; normal_in = n; material_in = m;
    @(posedge clk_in);
    model_beat(id, p, n, m, fl);
    #1;
    valid_in = 1'b0;
    flush_in = 1'b0;
  endtask

  task automatic send_tri(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
  endtask

  task automatic flush_only();
    flush_in = 1'b1;
    @(posedge clk_in);
    m_slot = 0;
    #1;
    flush_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    model_reset();
    #1;
    check("rst_valid", W'(valid_out), W'(1'b0));
    check("rst_cull", W'(cull_count_out), W'(16'd0));
    check("rst_ovf", W'(overflow_out), W'(1'b0));
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    ready_in = 1'b1;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk_in);
      #1;
      t++;
    end
    check("drain_left", W'(exp_q.size()), W'(0));
    idle(1);
  endtask

  // Scoreboard: status every cycle, head triangle whenever one is presented.
  always @(negedge clk_in) begin
    if (rst_in) begin
      check("valid_out", W'(valid_out), W'(exp_q.size() != 0));
      check("cull_count", W'(cull_count_out), W'(exp_cull));
      check("overflow", W'(overflow_out), W'(exp_ovf));
      if (valid_out && exp_q.size() != 0) begin
        check("head_tri", W'({tri_id_out, material_out, position_out, normal_out}), exp_q[0]);
        if (ready_in) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset values
    do_reset();
    ready_in = 1'b1;
    idle(1);

    // Degenerate 7,7,9 then six clean beats: tri_id 0 and 1
    send_tri(16'd7, 16'd7, 16'd9);
    idle(2);
    for (int i = 0; i < 6; i++) send(16'(i), 1'b0);
    drain();

    // Other degenerate shapes: ids repeat at positions 0/2 and 1/2
    send_tri(16'd1, 16'd2, 16'd1);
    send_tri(16'd3, 16'd4, 16'd4);
    send_tri(16'hFFFF, 16'h0000, 16'h8000);
    drain();

    // Hold with ready low: five triangles, four kept, overflow set
    do_reset();
    ready_in = 1'b0;
    for (int t = 0; t < 5; t++) send_tri(16'(10 * t), 16'(10 * t + 1), 16'(10 * t + 2));
    idle(3);
    check("ovf_after_fill", W'(overflow_out), W'(1'b1));
    drain();
    idle(2);
    check("ovf_sticky", W'(overflow_out), W'(1'b1));

    // Full FIFO with push and pop on the same edge: no overflow
    do_reset();
    ready_in = 1'b0;
    for (int t = 0; t < 4; t++) send_tri(16'(100 + 3 * t), 16'(101 + 3 * t), 16'(102 + 3 * t));
    idle(2);
    send(16'd200, 1'b0);
    send(16'd201, 1'b0);
    ready_in = 1'b1;
    send(16'd202, 1'b0);
    ready_in = 1'b0;
    idle(1);
    check("ovf_push_pop", W'(overflow_out), W'(1'b0));
    drain();

    // Flush with a beat restarts the triangle at slot 0
    send(16'd300, 1'b0);
    send(16'd301, 1'b0);
    send(16'd302, 1'b1);
    send(16'd303, 1'b0);
    send(16'd304, 1'b0);
    idle(2);
    // Flush without a beat discards the partial triangle
    send(16'd310, 1'b0);
    send(16'd311, 1'b0);
    flush_only();
    send_tri(16'd320, 16'd321, 16'd322);
    drain();

    // Reset mid-triangle with one triangle queued
    ready_in = 1'b0;
    send_tri(16'd400, 16'd401, 16'd402);
    send(16'd403, 1'b0);
    send(16'd404, 1'b0);
    do_reset();
    ready_in = 1'b1;
    send_tri(16'd500, 16'd501, 16'd502);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/primitive_assembly.md
PRIMITIVE_ASSEMBLY -- requirements
Module: primitive_assembly

Interface
REQ-001 Parameter: DEPTH, 4, triangle FIFO entries; power of two, >= 2.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  1  vertex beat present; no ready back to the producer, every valid beat is consumed.
REQ-005 vertex_id_in  input  16  vertex index of the beat.
REQ-006 position_in  input  [2:0][31:0]  vertex position x,y,z.
REQ-007 normal_in  input  [2:0][31:0]  vertex normal x,y,z.
REQ-008 material_in  input  12  material id of the beat.
REQ-009 flush_in  input  1  discard any partially assembled triangle.
REQ-010 ready_in  input  1  downstream accepts the triangle at the FIFO head.
REQ-011 valid_out  output  1  a triangle is available at the FIFO head.
REQ-012 position_out  output  [2:0][2:0][31:0]  positions of vertices 0,1,2 (index [0] = first received).
REQ-013 normal_out  output  [2:0][2:0][31:0]  normals of vertices 0,1,2.
REQ-014 material_out  output  12  material of vertex 0.
REQ-015 tri_id_out  output  16  sequence number of the head triangle.
REQ-016 cull_count_out  output  16  number of degenerate triangles dropped; wraps at 2^16.
REQ-017 overflow_out  output  1  sticky: a triangle was lost to a full FIFO.

Function
REQ-018 A 2-bit slot counter (0,1,2) shall select where each valid_in beat is stored; it advances 0->1->2->0 on each valid beat and never takes value 3.
REQ-019 A beat accepted in slot 2 completes a triangle from slots 0,1 and the current beat, using the current beat's data directly, without an extra cycle of storage.
REQ-020 A completed triangle is degenerate when any two of its three vertex_ids are equal; a degenerate triangle shall not be pushed, and cull_count_out shall increment by 1 on the following edge.
REQ-021 A non-degenerate completed triangle shall be pushed with tri_id equal to an internal 16-bit push counter, which then increments and wraps from 0xFFFF to 0.
REQ-022 Latency: with the FIFO empty, valid_out shall assert on the rising edge after the third vertex is sampled, with that triangle on the outputs.
REQ-023 valid_out shall equal FIFO not-empty; the outputs shall present the head entry and stay stable while valid_out=1 and ready_in=0.
REQ-024 A pop shall occur on a rising edge where valid_out=1 and ready_in=1.
REQ-025 A push into a full FIFO with no pop on the same edge shall drop the triangle, leave the FIFO and push counter unchanged, and set overflow_out.
REQ-026 A push and a pop on the same edge shall both take effect, including when the FIFO is full.
REQ-027 flush_in=1 shall reset the slot counter to 0 and discard stored partial vertices; FIFO contents and counters are unaffected.
REQ-028 flush_in=1 together with valid_in=1 shall store that beat as slot 0 of a new triangle, so the slot counter becomes 1.
REQ-029 Full and empty shall be distinguished by an extra pointer wrap bit; pointers wrap modulo DEPTH.

Reset
REQ-030 On rst_in=0, asynchronously: slot counter=0, FIFO empty, valid_out=0, push counter=0, cull_count_out=0, overflow_out=0.
REQ-031 Reset mid-triangle shall discard partial vertices; the first valid beat after rst_in=1 is slot 0.
REQ-032 overflow_out shall clear only by reset.
REQ-033 Data outputs are don't-care while valid_out=0.

Verification
REQ-034 Six beats with ids 0,1,2,3,4,5, ready_in=1 -> two triangles, tri_id 0 then 1, each with valid_out high 1 cycle after its third beat; positions in arrival order.
REQ-035 Beats with ids 7,7,9 -> no valid_out, cull_count_out=1, the next triangle has tri_id 0.
REQ-036 ready_in=0, DEPTH=4, 5 non-degenerate triangles -> 4 held, overflow_out=1; then ready_in=1 -> pops tri_id 0..3 in order.
REQ-037 FIFO full, fifth triangle completes on the same edge ready_in=1 pops -> no overflow; tri_id 4 is accepted.
REQ-038 Two beats, then flush_in=1 with a third beat, then two more beats -> one triangle made of the last three beats.
REQ-039 Reset asserted after two beats with one triangle queued -> valid_out=0 immediately; after release, three beats -> a triangle with tri_id 0.
